// File: rtl/fetch_ifid.sv
// Fetch stage with IF/ID register, one-word holding buffer and
// variable-latency imem req/done handshake.
//
// Ports:
//   clk, rst (async, active-low)
//   Stall, redirect_valid, redirect_pc, halt : control from decode
//   imem_req/imem_addr out, imem_rdata/imem_done in : instruction memory
//   instruction, PC_2, if_valid : IF/ID register to decode
//   fetch_stall : IF/ID bubbled because memory is busy
//   err : sticky misaligned-fetch flag (only when FETCH_ALIGN_ERR_EN defined)
//
// Optional feature macro: FETCH_ALIGN_ERR_EN
module fetch_ifid #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    input  logic [15:0] imem_rdata,
    input  logic        imem_done,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    output logic [15:0] instruction,
    output logic [15:0] PC_2,
    output logic        if_valid,
    output logic        fetch_stall,
    output logic        err
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_DRAIN,
        S_HALT
    } state_t;

    state_t      r_state;
    logic [15:0] r_pc;
    logic [15:0] r_addr;
    logic [15:0] r_instr;
    logic [15:0] r_pc2;
    logic        r_valid;
    logic        r_buf_full;
    logic [15:0] r_buf_instr;
    logic [15:0] r_buf_pc2;
    logic        r_buf_valid;
    logic        r_halt_pend;

    state_t      w_nxt_state;
    logic [15:0] w_nxt_pc;
    logic [15:0] w_nxt_instr;
    logic [15:0] w_nxt_pc2;
    logic        w_nxt_valid;
    logic        w_nxt_buf_full;
    logic [15:0] w_nxt_buf_instr;
    logic [15:0] w_nxt_buf_pc2;
    logic        w_nxt_buf_valid;
    logic        w_nxt_halt_pend;

    logic        w_req;
    logic [15:0] w_addr;
    logic        w_take;
    logic        w_bad;
    logic [15:0] w_word;
    logic [15:0] w_pc_inc;

    // A full buffer blocks new requests only while decode is stalled;
    // the cycle it drains, the next request goes out.
    assign w_req = ((r_state == S_FETCH) && (!r_buf_full || !Stall))
                 || (r_state == S_WAIT) || (r_state == S_DRAIN);
    // Outstanding accesses keep their latched address, even after the
    // PC has been redirected.
    assign w_addr   = (r_state == S_FETCH) ? r_pc : r_addr;
    assign w_take   = w_req && imem_done && (r_state != S_DRAIN);
    assign w_pc_inc = r_pc + 16'd2;

`ifdef FETCH_ALIGN_ERR_EN
    logic r_err;
    assign w_bad = w_addr[0];
    assign err   = r_err;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_err <= 1'b0;
        else if (w_req && w_addr[0]) r_err <= 1'b1;
    end
`else
    assign w_bad = 1'b0;
    assign err   = 1'b0;
`endif

    assign w_word      = w_bad ? NOP_INSTR : imem_rdata;
    assign imem_req    = w_req;
    assign imem_addr   = w_addr;
    assign instruction = r_instr;
    assign PC_2        = r_pc2;
    assign if_valid    = r_valid;
    assign fetch_stall = (r_state != S_HALT) && !Stall
                       && !r_buf_full && !w_take;

    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_pc        = r_pc;
        w_nxt_instr     = r_instr;
        w_nxt_pc2       = r_pc2;
        w_nxt_valid     = r_valid;
        w_nxt_buf_full  = r_buf_full;
        w_nxt_buf_instr = r_buf_instr;
        w_nxt_buf_pc2   = r_buf_pc2;
        w_nxt_buf_valid = r_buf_valid;
        w_nxt_halt_pend = r_halt_pend;
        if (redirect_valid && (r_state != S_HALT)) begin
            w_nxt_pc        = redirect_pc;
            w_nxt_buf_full  = 1'b0;
            w_nxt_instr     = NOP_INSTR;
            w_nxt_valid     = 1'b0;
            w_nxt_halt_pend = 1'b0;
            w_nxt_state     = (w_req && !imem_done) ? S_DRAIN : S_FETCH;
        end else if (halt && !Stall && (r_state != S_HALT)) begin
            w_nxt_buf_full  = 1'b0;
            w_nxt_instr     = NOP_INSTR;
            w_nxt_valid     = 1'b0;
            w_nxt_halt_pend = 1'b1;
            w_nxt_state     = (w_req && !imem_done) ? S_DRAIN : S_HALT;
        end else begin
            unique case (r_state)
                S_HALT: begin
                    w_nxt_instr = NOP_INSTR;
                    w_nxt_valid = 1'b0;
                end
                S_DRAIN: begin
                    if (imem_done)
                        w_nxt_state = r_halt_pend ? S_HALT : S_FETCH;
                    if (!Stall) begin
                        w_nxt_instr = NOP_INSTR;
                        w_nxt_valid = 1'b0;
                    end
                end
                S_FETCH, S_WAIT: begin
                    if (w_take) begin
                        w_nxt_pc    = w_pc_inc;
                        w_nxt_state = S_FETCH;
                        if (r_buf_full) begin
                            // Buffer feeds IF/ID; new word refills it.
                            w_nxt_instr     = r_buf_instr;
                            w_nxt_pc2       = r_buf_pc2;
                            w_nxt_valid     = r_buf_valid;
                            w_nxt_buf_instr = w_word;
                            w_nxt_buf_pc2   = w_pc_inc;
                            w_nxt_buf_valid = !w_bad;
                        end else if (!Stall) begin
                            w_nxt_instr = w_word;
                            w_nxt_pc2   = w_pc_inc;
                            w_nxt_valid = !w_bad;
                        end else begin
                            w_nxt_buf_full  = 1'b1;
                            w_nxt_buf_instr = w_word;
                            w_nxt_buf_pc2   = w_pc_inc;
                            w_nxt_buf_valid = !w_bad;
                        end
                    end else begin
                        if (w_req) w_nxt_state = S_WAIT;
                        if (r_buf_full && !Stall) begin
                            w_nxt_instr    = r_buf_instr;
                            w_nxt_pc2      = r_buf_pc2;
                            w_nxt_valid    = r_buf_valid;
                            w_nxt_buf_full = 1'b0;
                        end else if (!Stall) begin
                            w_nxt_instr = NOP_INSTR;
                            w_nxt_valid = 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_FETCH;
            r_pc        <= RESET_PC;
            r_addr      <= RESET_PC;
            r_instr     <= NOP_INSTR;
            r_pc2       <= 16'h0000;
            r_valid     <= 1'b0;
            r_buf_full  <= 1'b0;
            r_buf_instr <= NOP_INSTR;
            r_buf_pc2   <= 16'h0000;
            r_buf_valid <= 1'b0;
            r_halt_pend <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_pc        <= w_nxt_pc;
            r_addr      <= w_addr;
            r_instr     <= w_nxt_instr;
            r_pc2       <= w_nxt_pc2;
            r_valid     <= w_nxt_valid;
            r_buf_full  <= w_nxt_buf_full;
            r_buf_instr <= w_nxt_buf_instr;
            r_buf_pc2   <= w_nxt_buf_pc2;
            r_buf_valid <= w_nxt_buf_valid;
            r_halt_pend <= w_nxt_halt_pend;
        end
    end

endmodule

// File: tb/tb_fetch_ifid.sv
// Directed bench for fetch_ifid with a scoreboard of expected
// IF/ID entries and a simple stallable instruction memory.
module tb_fetch_ifid;

    logic        clk = 1'b0;
    logic        rst;
    logic        Stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt;
    logic [15:0] imem_rdata;
    logic        imem_done;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] instruction;
    logic [15:0] PC_2;
    logic        if_valid;
    logic        fetch_stall;
    logic        err;

    logic        mem_hold;
    logic [15:0] exp_pc;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        logic [15:0] ins;
        logic [15:0] pc2;
    } exp_t;
    exp_t q[$];

    localparam logic [15:0] NOP = 16'h0800;

    always #5 clk = ~clk;

    fetch_ifid dut (
        .clk(clk), .rst(rst), .Stall(Stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt(halt), .imem_rdata(imem_rdata), .imem_done(imem_done),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .instruction(instruction), .PC_2(PC_2), .if_valid(if_valid),
        .fetch_stall(fetch_stall), .err(err)
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C96;
    endfunction

    assign imem_done  = imem_req && !mem_hold;
    assign imem_rdata = mem_word(imem_addr);

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_word();
        exp_t e;
        e.ins = mem_word(exp_pc);
        e.pc2 = exp_pc + 16'd2;
        q.push_back(e);
        exp_pc = exp_pc + 16'd2;
    endtask

    task automatic run_words(input int n);
        mem_hold = 1'b0;
        repeat (n) push_word();
        step(n);
        mem_hold = 1'b1;
    endtask

    task automatic do_redirect(input logic [15:0] t);
        logic [15:0] old;
        old = exp_pc;
        redirect_valid = 1'b1;
        redirect_pc = t;
        mem_hold = 1'b1;
        step(1);
        redirect_valid = 1'b0;
        #1;
        chk("drain_req", imem_req, 1'b1);
        chk("drain_addr", imem_addr, old);
        chk("redir_valid", if_valid, 1'b0);
        chk("redir_instr", instruction, NOP);
        mem_hold = 1'b0;
        step(1);
        mem_hold = 1'b1;
        #1;
        chk("redir_req", imem_req, 1'b1);
        chk("redir_addr", imem_addr, t);
        exp_pc = t;
    endtask

    // Monitor: checks IF/ID against the scoreboard, hold on stall,
    // and req/addr stability while an access is outstanding.
    always @(posedge clk) begin
        logic        st, rv, act, ob, pv;
        logic [15:0] pi, pp, oa;
        exp_t        e;
        st  = Stall;
        rv  = redirect_valid;
        act = rst;
        pi  = instruction;
        pp  = PC_2;
        pv  = if_valid;
        ob  = imem_req && !imem_done;
        oa  = imem_addr;
        #1;
        if (act && rst) begin
            if (ob) begin
                chk("req_hold", imem_req, 1'b1);
                chk("addr_hold", imem_addr, oa);
            end
            if (st && !rv) begin
                chk("stall_instr", instruction, pi);
                chk("stall_pc2", PC_2, pp);
                chk("stall_valid", if_valid, pv);
            end else if (!st && if_valid) begin
                checks++;
                assert (q.size() != 0) else begin
                    failures++;
                    $error("FAIL unexp_entry got=%h/%h want=none",
                           instruction, PC_2);
                end
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("entry_instr", instruction, e.ins);
                    chk("entry_pc2", PC_2, e.pc2);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        Stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 16'h0000;
        halt = 1'b0;
        mem_hold = 1'b1;
        exp_pc = 16'h0000;
        #2 rst = 1'b0;
        step(2);
        chk("rst_instr", instruction, NOP);
        chk("rst_pc2", PC_2, 16'h0000);
        chk("rst_valid", if_valid, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_req", imem_req, 1'b1);
        chk("rst_addr", imem_addr, 16'h0000);

        // Back-to-back single-cycle fetches.
        rst = 1'b1;
        mem_hold = 1'b0;
        push_word();
        step(1);
        chk("lat1_pc2", PC_2, 16'h0002);
        chk("lat1_valid", if_valid, 1'b1);
        run_words(3);

        // Slow memory: request held, IF/ID bubbles.
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("late_req", imem_req, 1'b1);
            chk("late_addr", imem_addr, exp_pc);
            chk("late_fstall", fetch_stall, 1'b1);
            if (i > 0) chk("late_bubble", if_valid, 1'b0);
            step(1);
        end
        run_words(1);
        #1;
        chk("late_pc2", PC_2, 16'h000A);

        // Decode stall for 4 cycles with one word buffered.
        mem_hold = 1'b0;
        push_word();
        step(1);
        Stall = 1'b1;
        push_word();
        step(1);
        for (int i = 0; i < 3; i++) begin
            chk("stall_noreq", imem_req, 1'b0);
            step(1);
        end
        Stall = 1'b0;
        push_word();
        step(1);
        mem_hold = 1'b1;
        step(1);
        chk("stall_q", 16'(q.size()), 16'h0000);

        // Redirect while waiting on memory.
        do_redirect(16'h0040);
        run_words(2);
        #1;
        chk("redir_pc2", PC_2, 16'h0044);

        // PC wrap at the top of the address space.
        do_redirect(16'hFFFE);
        run_words(1);
        #1;
        chk("wrap_pc2", PC_2, 16'h0000);
        run_words(1);

        // Misaligned redirect target.
        do_redirect(16'h0041);
`ifdef FETCH_ALIGN_ERR_EN
        mem_hold = 1'b0;
        step(1);
        mem_hold = 1'b1;
        #1;
        chk("mis_valid", if_valid, 1'b0);
        chk("mis_instr", instruction, NOP);
        chk("mis_err", err, 1'b1);
        exp_pc = exp_pc + 16'd2;
`else
        push_word();
        mem_hold = 1'b0;
        step(1);
        mem_hold = 1'b1;
        #1;
        chk("mis_err", err, 1'b0);
`endif
        do_redirect(16'h0080);
        run_words(1);
        #1;
`ifdef FETCH_ALIGN_ERR_EN
        chk("err_sticky", err, 1'b1);
`else
        chk("err_tied", err, 1'b0);
`endif

        // Halt: drain the outstanding access, then stop.
        halt = 1'b1;
        step(1);
        halt = 1'b0;
        #1;
        chk("halt_drain_req", imem_req, 1'b1);
        chk("halt_valid", if_valid, 1'b0);
        chk("halt_instr", instruction, NOP);
        mem_hold = 1'b0;
        step(1);
        #1;
        chk("halt_noreq", imem_req, 1'b0);
        step(4);
        chk("halt_stay_req", imem_req, 1'b0);
        chk("halt_stay_valid", if_valid, 1'b0);
        redirect_valid = 1'b1;
        redirect_pc = 16'h0100;
        step(1);
        redirect_valid = 1'b0;
        #1;
        chk("halt_ignore_redir", imem_req, 1'b0);
        chk("halt_q", 16'(q.size()), 16'h0000);

        // Only reset leaves HALT.
        mem_hold = 1'b1;
        rst = 1'b0;
        #1;
        chk("rst2_instr", instruction, NOP);
        chk("rst2_valid", if_valid, 1'b0);
        chk("rst2_req", imem_req, 1'b1);
        chk("rst2_err", err, 1'b0);
        step(1);
        rst = 1'b1;
        exp_pc = 16'h0000;
        run_words(2);
        step(1);
        chk("final_q", 16'(q.size()), 16'h0000);
        chk("final_pc2", PC_2, 16'h0004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
